stream_demux: RTL and testbench

//  - Valid/ready stream demultiplexer. Routes each input beat to one of N_OUT output channels, chosen by the in_sel value that arrives with the beat.
//  - This is the fan-out counterpart of the mux primitive.
//  - Sits between a single producer and N_OUT consumers.
//  - A 2-entry skid buffer registers in_ready and sustains 1 beat/cycle.

---
 rtl/stream_demux_pkg.sv | 26 ++
 rtl/stream_demux_onehot.sv | 24 ++
 rtl/stream_demux.sv | 144 ++++++++++++++
 tb/tb_stream_demux.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and widths for the stream demultiplexer.
//   entry_t    - one buffered beat {sel, data}, sized for the default channel
//                count and payload width; override the package widths together
//                with the stream_demux parameters.
//   occ_e      - skid buffer occupancy (EMPTY, ONE, TWO).
//   DROP_CNT_W - width of the dropped-beat counter (STREAM_DEMUX_ERR_EN builds).
package stream_demux_pkg;

    localparam int unsigned DEF_N_OUT    = 3;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned ENTRY_SEL_W  = $clog2(DEF_N_OUT);
    localparam int unsigned ENTRY_DATA_W = DEF_DATA_W;
    localparam int unsigned DROP_CNT_W   = 8;

    typedef struct packed {
        logic [ENTRY_SEL_W-1:0]  sel;
        logic [ENTRY_DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/stream_demux_onehot.sv
// demux_onehot: combinational select decoder.
//   valid  in   1      qualifies the select
//   sel    in   SEL_W  channel index
//   onehot out  N_OUT  bit sel set when valid and sel < N_OUT, else all zero
module demux_onehot
    import stream_demux_pkg::*;
#(
    parameter int unsigned N_OUT = DEF_N_OUT,
    parameter int unsigned SEL_W = $clog2(N_OUT)
) (
    input  logic             valid,
    input  logic [SEL_W-1:0] sel,
    output logic [N_OUT-1:0] onehot
);

    // Out-of-range selects match no bit and so decode to zero.
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            onehot[i] = valid && (32'(sel) == i);
        end
    end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: valid/ready demultiplexer with a 2-entry skid buffer.
// Each accepted beat is stored and later presented on channel in_sel; beats
// leave in strict arrival order across all channels. in_ready is registered.
// Beats whose in_sel >= N_OUT are accepted and discarded.
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    producer handshake
//   in_data, in_sel      payload and destination channel
//   out_valid[N_OUT]     one-hot (or zero) head-valid per channel
//   out_ready[N_OUT]     per-channel consumer ready
//   out_data             head payload, shared by all channels (0 when empty)
//   err, drop_cnt        only with STREAM_DEMUX_ERR_EN: sticky bad-select flag
//                        and saturating count of dropped beats
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int unsigned N_OUT  = DEF_N_OUT,
    parameter  int unsigned DATA_W = DEF_DATA_W,
    localparam int unsigned SEL_W  = $clog2(N_OUT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [SEL_W-1:0]      in_sel,
    output logic [N_OUT-1:0]      out_valid,
    input  logic [N_OUT-1:0]      out_ready,
    output logic [DATA_W-1:0]     out_data
`ifdef STREAM_DEMUX_ERR_EN
    ,
    output logic                  err,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    occ_e   state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t in_entry_c;
    logic   in_ready_q;
    logic   sel_ok_c;
    logic   in_xfer_c;
    logic   push_c;
    logic   pop_c;

    // Input handshake qualification; only in-range selects are stored.
    always_comb begin
        sel_ok_c        = (32'(in_sel) < N_OUT);
        in_xfer_c       = in_valid && in_ready_q;
        push_c          = in_xfer_c && sel_ok_c;
        in_entry_c.sel  = in_sel;
        in_entry_c.data = in_data;
    end

    // Head decode; out_ready of non-head channels is masked off here.
    demux_onehot #(
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) u_onehot (
        .valid  (state_q != EMPTY),
        .sel    (head_q.sel),
        .onehot (out_valid)
    );

    assign pop_c    = |(out_valid & out_ready);
    assign out_data = (state_q != EMPTY) ? head_q.data : '0;
    assign in_ready = in_ready_q;

    // Occupancy and entry movement.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (push_c) begin
                    head_d  = in_entry_c;
                    state_d = ONE;
                end
            end
            ONE: begin
                unique case ({push_c, pop_c})
                    2'b10: begin
                        tail_d  = in_entry_c;
                        state_d = TWO;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: head_d  = in_entry_c;
                    default: ;
                endcase
            end
            TWO: begin
                // in_ready is low in TWO, so only a pop can happen.
                if (pop_c) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register; in_ready is held low through reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= (state_d != TWO);
        end
    end

`ifdef STREAM_DEMUX_ERR_EN
    logic                  drop_c;
    logic                  err_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    assign drop_c = in_xfer_c && !sel_ok_c;

    // Sticky error flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop_c) begin
            err_q <= 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
            end
        end
    end

    assign err      = err_q;
    assign drop_cnt = drop_cnt_q;
`else
    // Bad-select beats complete their handshake and are simply not stored.
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed, table-driven bench for stream_demux (N_OUT=3, DATA_W=8).
// Inputs are driven 1 time unit after the rising edge; outputs are compared
// in the same window, so each row's expectations describe the state left by
// the previous edge.
module tb_stream_demux;

    localparam int unsigned N_OUT  = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]  in_sel;
    logic [N_OUT-1:0]  out_valid;
    logic [N_OUT-1:0]  out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef STREAM_DEMUX_ERR_EN
    logic              err;
    logic [7:0]        drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stream_demux #(
        .N_OUT  (N_OUT),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef STREAM_DEMUX_ERR_EN
        ,
        .err       (err),
        .drop_cnt  (drop_cnt)
`endif
    );

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [2:0]  ordy;
        logic        exp_ir;
        logic [2:0]  exp_ov;
        logic [7:0]  exp_od;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [1:0] sel, input logic [7:0] data,
                       input logic [2:0] ordy, input logic exp_ir,
                       input logic [2:0] exp_ov, input logic [7:0] exp_od);
        vec_t v;
        v.iv = iv; v.sel = sel; v.data = data; v.ordy = ordy;
        v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_od = exp_od;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [1:0] sel, input logic [7:0] data,
                         input logic [2:0] ordy);
        in_valid  = iv;
        in_sel    = sel;
        in_data   = data;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ir, input logic [2:0] ov,
                              input logic [7:0] od);
        check({tag, " in_ready"}, 32'(in_ready), 32'(ir));
        check({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, " out_data"}, 32'(out_data), 32'(od));
    endtask

    initial begin
        // iv sel data ordy | in_ready out_valid out_data
        // Streaming, one beat per cycle.
        add(1, 0, 8'h11, 3'b111, 1, 3'b000, 8'h00);
        add(1, 1, 8'h22, 3'b111, 1, 3'b001, 8'h11);
        add(1, 2, 8'h33, 3'b111, 1, 3'b010, 8'h22);
        add(0, 0, 8'h00, 3'b111, 1, 3'b100, 8'h33);
        add(0, 0, 8'h00, 3'b111, 1, 3'b000, 8'h00);
        // Backpressure: two accepted, third held off, then drain in order.
        add(1, 0, 8'hA0, 3'b000, 1, 3'b000, 8'h00);
        add(1, 1, 8'hA1, 3'b000, 1, 3'b001, 8'hA0);
        add(1, 2, 8'hA2, 3'b000, 0, 3'b001, 8'hA0);
        add(1, 2, 8'hA2, 3'b000, 0, 3'b001, 8'hA0);
        add(1, 2, 8'hA2, 3'b001, 0, 3'b001, 8'hA0);
        add(1, 2, 8'hA2, 3'b010, 1, 3'b010, 8'hA1);
        add(0, 0, 8'h00, 3'b100, 1, 3'b100, 8'hA2);
        // Head-of-line: sel-2 head stalls a sel-0 beat behind it.
        add(1, 2, 8'hB2, 3'b011, 1, 3'b000, 8'h00);
        add(1, 0, 8'hB0, 3'b011, 1, 3'b100, 8'hB2);
        add(0, 0, 8'h00, 3'b011, 0, 3'b100, 8'hB2);
        add(0, 0, 8'h00, 3'b011, 0, 3'b100, 8'hB2);
        add(0, 0, 8'h00, 3'b100, 0, 3'b100, 8'hB2);
        add(0, 0, 8'h00, 3'b110, 1, 3'b001, 8'hB0);
        add(0, 0, 8'h00, 3'b001, 1, 3'b001, 8'hB0);
        add(0, 0, 8'h00, 3'b111, 1, 3'b000, 8'h00);
        // Bad select while empty: accepted, never shown.
        add(1, 3, 8'hEE, 3'b111, 1, 3'b000, 8'h00);
        add(0, 0, 8'h00, 3'b111, 1, 3'b000, 8'h00);
        // Bad select together with a pop: pop only.
        add(1, 1, 8'hC1, 3'b000, 1, 3'b000, 8'h00);
        add(1, 3, 8'hEE, 3'b010, 1, 3'b010, 8'hC1);
        add(0, 0, 8'h00, 3'b111, 1, 3'b000, 8'h00);
        // Bad select while ONE without pop: occupancy stays ONE.
        add(1, 2, 8'hD2, 3'b000, 1, 3'b000, 8'h00);
        add(1, 3, 8'hEE, 3'b000, 1, 3'b100, 8'hD2);
        add(0, 0, 8'h00, 3'b000, 1, 3'b100, 8'hD2);
        add(0, 0, 8'h00, 3'b100, 1, 3'b100, 8'hD2);
        add(0, 0, 8'h00, 3'b000, 1, 3'b000, 8'h00);

        // Reset held 3 cycles with in_valid asserted.
        rst_n = 1'b0;
        drive(1, 0, 8'h55, 3'b111);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs($sformatf("reset%0d", i), 1'b0, 3'b000, 8'h00);
        end
        rst_n = 1'b1;
        drive(0, 0, 8'h00, 3'b111);
        tick();
        check_outs("post_reset", 1'b1, 3'b000, 8'h00);
`ifdef STREAM_DEMUX_ERR_EN
        check("post_reset err", 32'(err), 32'd0);
        check("post_reset drop_cnt", 32'(drop_cnt), 32'd0);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].sel, vecs[i].data, vecs[i].ordy);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_od);
            tick();
        end

`ifdef STREAM_DEMUX_ERR_EN
        check("table err", 32'(err), 32'd1);
        check("table drop_cnt", 32'(drop_cnt), 32'd3);
        // Saturation: 300 more bad-select beats.
        drive(1, 3, 8'hEE, 3'b111);
        for (int i = 0; i < 300; i++) tick();
        drive(0, 0, 8'h00, 3'b111);
        check("sat drop_cnt", 32'(drop_cnt), 32'd255);
        check("sat err", 32'(err), 32'd1);
        check("sat out_valid", 32'(out_valid), 32'd0);
        tick();
`endif

        // Mid-flight reset with the buffer full.
        drive(1, 0, 8'hE0, 3'b000);
        tick();
        drive(1, 1, 8'hE1, 3'b000);
        tick();
        drive(0, 0, 8'h00, 3'b000);
        check_outs("full", 1'b0, 3'b001, 8'hE0);
        rst_n = 1'b0;
        tick();
        check_outs("midrst", 1'b0, 3'b000, 8'h00);
`ifdef STREAM_DEMUX_ERR_EN
        check("midrst err", 32'(err), 32'd0);
        check("midrst drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        drive(0, 0, 8'h00, 3'b111);
        tick();
        check_outs("midrst_rel", 1'b1, 3'b000, 8'h00);
        tick();
        check_outs("midrst_idle", 1'b1, 3'b000, 8'h00);
        drive(1, 2, 8'h5A, 3'b000);
        tick();
        drive(0, 0, 8'h00, 3'b000);
        check_outs("midrst_push", 1'b1, 3'b100, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
